// File: rtl/cache_trace_capture.sv
// cache_trace_capture: address-filtered event trace buffer for the cache-to-memory
// interface. Captures {channel, address, data} per cycle from the lowest-index
// qualifying channel, in fill-once or circular mode, with registered readback once
// capture has finished.
module cache_trace_capture #(
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned NCH   = 2,
   localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int unsigned IW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              stop,
   input  logic              clear,
   input  logic              mode,
   input  logic [AW-1:0]     addr_mask,
   input  logic [AW-1:0]     addr_match,
   input  logic [NCH-1:0]    ev_valid,
   input  logic [NCH*AW-1:0] ev_addr,
   input  logic [NCH*DW-1:0] ev_data,
   output logic [1:0]        state_o,
   output logic [IW:0]       count,
   output logic              wrapped,
   output logic [15:0]       drop_cnt,
   input  logic              rd_req,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic [CW-1:0]     rd_ch,
   output logic [AW-1:0]     rd_addr,
   output logic [DW-1:0]     rd_data
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   localparam int unsigned EW   = CW + AW + DW;
   localparam logic [IW:0] FULL = (IW + 1)'(DEPTH);

   state_e          state_q, state_d;
   logic            mode_q, mode_d;
   logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [IW:0]     count_q, count_d;
   logic            wrapped_q, wrapped_d;
   logic [15:0]     drop_q, drop_d;
   logic            rd_valid_q, rd_valid_d;
   logic [CW-1:0]   rd_ch_q, rd_ch_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic [DW-1:0]   rd_data_q, rd_data_d;

   logic [EW-1:0]   mem [DEPTH];

   logic [NCH-1:0]  qual;
   logic [3:0]      n_qual;
   logic            win_any;
   logic [CW-1:0]   win_ch;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_data;
   logic            we;
   logic [16:0]     drop_sum;
   logic [IW-1:0]   phys;

   // Filter every channel and pick the lowest-index qualifier as the winner.
   always_comb begin
      qual     = '0;
      n_qual   = '0;
      win_any  = 1'b0;
      win_ch   = '0;
      win_addr = '0;
      win_data = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         qual[i] = ev_valid[i] &&
                   ((ev_addr[i*AW +: AW] & addr_mask) == (addr_match & addr_mask));
         if (qual[i]) begin
            n_qual = n_qual + 4'd1;
            if (!win_any) begin
               win_any  = 1'b1;
               win_ch   = CW'(i);
               win_addr = ev_addr[i*AW +: AW];
               win_data = ev_data[i*DW +: DW];
            end
         end
      end
   end

   // Capture FSM: state, write pointer, occupancy, wrap flag and drop counter.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      wrapped_d = wrapped_q;
      drop_d    = drop_q;
      we        = 1'b0;
      drop_sum  = {1'b0, drop_q} + {13'd0, n_qual - 4'd1};
      if (clear) begin
         state_d   = S_IDLE;
         wr_ptr_d  = '0;
         count_d   = '0;
         wrapped_d = 1'b0;
         drop_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_d   = S_ARMED;
                  mode_d    = mode;
                  wr_ptr_d  = '0;
                  count_d   = '0;
                  wrapped_d = 1'b0;
               end
            end
            S_ARMED, S_CAPTURE: begin
               if (win_any) begin
                  we       = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  state_d  = S_CAPTURE;
                  if (count_q != FULL) count_d = count_q + 1'b1;
                  else                 wrapped_d = 1'b1;
                  if (!mode_q && (count_q + 1'b1 == FULL)) state_d = S_DONE;
               end
               if (n_qual > 4'd1) drop_d = drop_sum[16] ? '1 : drop_sum[15:0];
               // stop is applied after the write so a same-cycle winner is kept
               if (stop) state_d = S_DONE;
            end
            default: ;
         endcase
      end
   end

   // Readback: oldest-first indexing, zeros beyond the captured count.
   always_comb begin
      rd_valid_d = 1'b0;
      rd_ch_d    = rd_ch_q;
      rd_addr_d  = rd_addr_q;
      rd_data_d  = rd_data_q;
      phys       = wrapped_q ? (wr_ptr_q + rd_idx) : rd_idx;
      if (!clear && rd_req && (state_q == S_DONE)) begin
         rd_valid_d = 1'b1;
         if ({1'b0, rd_idx} < count_q) {rd_ch_d, rd_addr_d, rd_data_d} = mem[phys];
         else                          {rd_ch_d, rd_addr_d, rd_data_d} = '0;
      end
   end

   // Control and readback registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         wrapped_q  <= 1'b0;
         drop_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_ch_q    <= '0;
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         wrapped_q  <= wrapped_d;
         drop_q     <= drop_d;
         rd_valid_q <= rd_valid_d;
         rd_ch_q    <= rd_ch_d;
         rd_addr_q  <= rd_addr_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Trace storage, deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr_q] <= {win_ch, win_addr, win_data};
   end

   assign state_o  = state_q;
   assign count    = count_q;
   assign wrapped  = wrapped_q;
   assign drop_cnt = drop_q;
   assign rd_valid = rd_valid_q;
   assign rd_ch    = rd_ch_q;
   assign rd_addr  = rd_addr_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_cache_trace_capture.sv
// Testbench for cache_trace_capture: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the trace buffer.
module tb_cache_trace_capture;

   localparam int NCH   = 2;
   localparam int DEPTH = 16;

   logic        clk, rst_n, arm, stop, clear, mode, rd_req;
   logic [31:0] addr_mask, addr_match;
   logic [1:0]  ev_valid;
   logic [63:0] ev_addr, ev_data;
   logic [1:0]  state_o;
   logic [4:0]  count;
   logic        wrapped, rd_valid;
   logic [15:0] drop_cnt;
   logic [3:0]  rd_idx;
   logic [0:0]  rd_ch;
   logic [31:0] rd_addr, rd_data;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        ch;
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   int          m_state, m_drop;
   logic        m_mode, m_wrapped, m_rdv, m_rch;
   logic [31:0] m_raddr, m_rdata;

   cache_trace_capture #(.AW(32), .DW(32), .DEPTH(DEPTH), .NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .clear(clear), .mode(mode),
      .addr_mask(addr_mask), .addr_match(addr_match), .ev_valid(ev_valid),
      .ev_addr(ev_addr), .ev_data(ev_data), .state_o(state_o), .count(count),
      .wrapped(wrapped), .drop_cnt(drop_cnt), .rd_req(rd_req), .rd_idx(rd_idx),
      .rd_valid(rd_valid), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_state = 0; m_drop = 0; m_mode = 0; m_wrapped = 0; m_rdv = 0;
      m_rch = 0; m_raddr = '0; m_rdata = '0;
      mq.delete();
   endtask

   // Reference behaviour for one clock edge, from the current inputs.
   task automatic model_update();
      int   wins[$];
      ent_t e;
      if (clear) begin
         m_state = 0; mq.delete(); m_wrapped = 0; m_drop = 0; m_rdv = 0;
         return;
      end
      if (rd_req && m_state == 3) begin
         m_rdv = 1;
         if (int'(rd_idx) < mq.size()) begin
            m_rch = mq[rd_idx].ch; m_raddr = mq[rd_idx].addr; m_rdata = mq[rd_idx].data;
         end else begin
            m_rch = 0; m_raddr = '0; m_rdata = '0;
         end
      end else m_rdv = 0;
      for (int i = 0; i < NCH; i++)
         if (ev_valid[i] && ((ev_addr[i*32 +: 32] & addr_mask) == (addr_match & addr_mask)))
            wins.push_back(i);
      case (m_state)
         0: if (arm) begin m_state = 1; m_mode = mode; mq.delete(); m_wrapped = 0; end
         1, 2: begin
            if (wins.size() > 0) begin
               e.ch = (wins[0] == 1); e.addr = ev_addr[wins[0]*32 +: 32];
               e.data = ev_data[wins[0]*32 +: 32];
               mq.push_back(e);
               if (mq.size() > DEPTH) begin void'(mq.pop_front()); m_wrapped = 1; end
               m_state = 2;
               m_drop = m_drop + wins.size() - 1;
               if (m_drop > 65535) m_drop = 65535;
               if (!m_mode && mq.size() == DEPTH) m_state = 3;
            end
            if (stop) m_state = 3;
         end
         default: ;
      endcase
   endtask

   task automatic step();
      model_update();
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      arm = 0; stop = 0; clear = 0; rd_req = 0; ev_valid = '0;
   endtask

   task automatic drive_ev(input int ch, input logic [31:0] a, input logic [31:0] d);
      ev_valid[ch] = 1'b1; ev_addr[ch*32 +: 32] = a; ev_data[ch*32 +: 32] = d;
   endtask

   task automatic pulse_clear(); clear = 1; step(); clear = 0; endtask
   task automatic do_arm(input logic m); mode = m; arm = 1; step(); arm = 0; endtask
   task automatic do_read(input int idx); rd_idx = idx[3:0]; rd_req = 1; step(); rd_req = 0; endtask

   task automatic test_reset();
      idle_in(); mode = 0; addr_mask = '0; addr_match = '0; ev_addr = '0; ev_data = '0; rd_idx = '0;
      rst_n = 0; model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (wrapped !== 1'b0 || drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_wrap_drop: got %b/%0d want 0/0", wrapped, drop_cnt); end
      n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd0 || rd_addr !== 32'd0 || rd_ch !== 1'b0) begin n_err++; $display("FAIL reset_rd: got v%b d%h want 0", rd_valid, rd_data); end
   endtask

   task automatic test_fill_once();
      pulse_clear(); addr_mask = '0; do_arm(0);
      for (int k = 0; k < 16; k++) begin
         ev_valid = '0; drive_ev(0, 32'h100 + 32'(4*k), 32'(k)); step();
         if (k == 14) begin
            n_cmp++; if (state_o !== 2'd2) begin n_err++; $display("FAIL fill_state15: got %0d want 2", state_o); end
         end
      end
      ev_valid = '0;
      n_cmp++; if (state_o !== 2'd3) begin n_err++; $display("FAIL fill_done: got %0d want 3", state_o); end
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", count); end
      do_read(5);
      n_cmp++; if (rd_valid !== 1'b1 || rd_addr !== 32'h114 || rd_data !== 32'd5 || rd_ch !== 1'b0) begin n_err++; $display("FAIL fill_rd5: got v%b a%h d%h c%b want 1/114/5/0", rd_valid, rd_addr, rd_data, rd_ch); end
      step();
      n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd5) begin n_err++; $display("FAIL fill_hold: got v%b d%h want 0/5", rd_valid, rd_data); end
   endtask

   task automatic test_circular();
      pulse_clear(); do_arm(1);
      for (int k = 0; k < 20; k++) begin
         ev_valid = '0; drive_ev(0, 32'h100 + 32'(4*k), 32'(k)); step();
      end
      ev_valid = '0; stop = 1; step(); stop = 0;
      n_cmp++; if (count !== 5'd16 || wrapped !== 1'b1 || state_o !== 2'd3) begin n_err++; $display("FAIL circ_status: got c%0d w%b s%0d want 16/1/3", count, wrapped, state_o); end
      do_read(0);
      n_cmp++; if (rd_data !== 32'd4 || rd_valid !== 1'b1) begin n_err++; $display("FAIL circ_rd0: got %0d want 4", rd_data); end
      do_read(15);
      n_cmp++; if (rd_data !== 32'd19) begin n_err++; $display("FAIL circ_rd15: got %0d want 19", rd_data); end
   endtask

   task automatic test_filter();
      logic [31:0] addrs [4];
      addrs[0] = 32'h1000; addrs[1] = 32'h2004; addrs[2] = 32'h3000; addrs[3] = 32'h2008;
      pulse_clear(); addr_mask = 32'hF000; addr_match = 32'h2000; do_arm(0);
      for (int k = 0; k < 4; k++) begin
         ev_valid = '0; drive_ev(0, addrs[k], 32'(k)); step();
      end
      ev_valid = '0; stop = 1; step(); stop = 0;
      n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL filt_count: got %0d want 2", count); end
      do_read(0);
      n_cmp++; if (rd_addr !== 32'h2004) begin n_err++; $display("FAIL filt_e0: got %h want 2004", rd_addr); end
      do_read(1);
      n_cmp++; if (rd_addr !== 32'h2008) begin n_err++; $display("FAIL filt_e1: got %h want 2008", rd_addr); end
      addr_mask = '0;
   endtask

   task automatic test_arbitration();
      pulse_clear(); do_arm(0);
      for (int k = 0; k < 3; k++) begin
         drive_ev(0, 32'h40 + 32'(k), 32'hA0 + 32'(k)); drive_ev(1, 32'h80 + 32'(k), 32'hB0 + 32'(k)); step();
      end
      ev_valid = '0; stop = 1; step(); stop = 0;
      n_cmp++; if (count !== 5'd3 || drop_cnt !== 16'd3) begin n_err++; $display("FAIL arb_count_drop: got %0d/%0d want 3/3", count, drop_cnt); end
      for (int k = 0; k < 3; k++) begin
         do_read(k);
         n_cmp++; if (rd_ch !== 1'b0 || rd_data !== 32'hA0 + 32'(k)) begin n_err++; $display("FAIL arb_entry%0d: got c%b d%h want 0/%h", k, rd_ch, rd_data, 32'hA0 + k); end
      end
      rd_req = 1; rd_idx = 0; clear = 1; step(); clear = 0; rd_req = 0;
      n_cmp++; if (state_o !== 2'd0 || count !== 5'd0 || drop_cnt !== 16'd0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL arb_clear: got s%0d c%0d d%0d v%b want 0/0/0/0", state_o, count, drop_cnt, rd_valid); end
   endtask

   task automatic test_corners();
      pulse_clear(); do_arm(0);
      drive_ev(0, 32'h10, 32'h11); step();
      drive_ev(0, 32'h14, 32'h22); stop = 1; step(); stop = 0; ev_valid = '0;
      n_cmp++; if (state_o !== 2'd3 || count !== 5'd2) begin n_err++; $display("FAIL stop_event: got s%0d c%0d want 3/2", state_o, count); end
      do_read(1);
      n_cmp++; if (rd_data !== 32'h22) begin n_err++; $display("FAIL stop_event_kept: got %h want 22", rd_data); end
      drive_ev(0, 32'h18, 32'h33); step(); ev_valid = '0;
      n_cmp++; if (count !== 5'd2 || drop_cnt !== 16'd0) begin n_err++; $display("FAIL done_ignores: got c%0d d%0d want 2/0", count, drop_cnt); end
      pulse_clear(); do_arm(0); stop = 1; step(); stop = 0;
      n_cmp++; if (state_o !== 2'd3 || count !== 5'd0) begin n_err++; $display("FAIL stop_armed: got s%0d c%0d want 3/0", state_o, count); end
      arm = 1; step(); arm = 0;
      n_cmp++; if (state_o !== 2'd3) begin n_err++; $display("FAIL arm_ignored: got %0d want 3", state_o); end
      do_read(5);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'd0 || rd_addr !== 32'd0 || rd_ch !== 1'b0) begin n_err++; $display("FAIL rd_oob: got v%b a%h d%h want 1/0/0", rd_valid, rd_addr, rd_data); end
   endtask

   task automatic test_async_reset();
      pulse_clear(); do_arm(0);
      for (int k = 0; k < 7; k++) begin
         ev_valid = '0; drive_ev(0, 32'h300 + 32'(k), 32'(k)); step();
      end
      ev_valid = '0;
      n_cmp++; if (count !== 5'd7) begin n_err++; $display("FAIL ar_pre: got %0d want 7", count); end
      #2 rst_n = 0;
      #1;
      model_reset();
      n_cmp++; if (state_o !== 2'd0 || count !== 5'd0 || wrapped !== 1'b0 || drop_cnt !== 16'd0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin n_err++; $display("FAIL ar_async: got s%0d c%0d want 0/0", state_o, count); end
      @(posedge clk); #1 rst_n = 1;
      do_arm(0); drive_ev(0, 32'h500, 32'hAB); step(); ev_valid = '0;
      stop = 1; step(); stop = 0;
      do_read(0);
      n_cmp++; if (count !== 5'd1 || rd_data !== 32'hAB || rd_addr !== 32'h500) begin n_err++; $display("FAIL ar_rearm: got c%0d d%h want 1/AB", count, rd_data); end
      do_read(1);
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin n_err++; $display("FAIL ar_stale: got v%b d%h want 1/0", rd_valid, rd_data); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         idle_in(); pulse_clear();
         addr_mask  = ($urandom_range(0, 1) != 0) ? 32'hF000 : 32'h0;
         addr_match = 32'h2000;
         do_arm(1'($urandom_range(0, 1)));
         for (int cyc = 0; cyc < 100; cyc++) begin
            idle_in();
            mode = 1'($urandom_range(0, 1));
            if (cyc < 80) begin
               for (int i = 0; i < NCH; i++)
                  if ($urandom_range(0, 2) != 0)
                     drive_ev(i, {16'h0, 4'($urandom_range(1, 3)), 12'($urandom)}, $urandom);
               stop   = ($urandom_range(0, 39) == 0);
               clear  = ($urandom_range(0, 79) == 0);
               arm    = ($urandom_range(0, 5) == 0);
               rd_req = ($urandom_range(0, 1) == 0);
               rd_idx = 4'($urandom);
            end else begin
               stop   = (cyc == 80);
               rd_req = (cyc > 80);
               rd_idx = 4'(cyc - 84);
            end
            step();
            n_cmp++; if (int'(state_o) !== m_state || int'(count) !== mq.size() || wrapped !== m_wrapped || int'(drop_cnt) !== m_drop) begin n_err++; $display("FAIL rnd_status r%0d c%0d: got s%0d n%0d w%b d%0d want s%0d n%0d w%b d%0d", r, cyc, state_o, count, wrapped, drop_cnt, m_state, mq.size(), m_wrapped, m_drop); end
            n_cmp++; if (rd_valid !== m_rdv || rd_ch !== m_rch || rd_addr !== m_raddr || rd_data !== m_rdata) begin n_err++; $display("FAIL rnd_read r%0d c%0d: got v%b c%b a%h d%h want v%b c%b a%h d%h", r, cyc, rd_valid, rd_ch, rd_addr, rd_data, m_rdv, m_rch, m_raddr, m_rdata); end
         end
      end
      idle_in();
   endtask

   initial begin
      test_reset();
      test_fill_once();
      test_circular();
      test_filter();
      test_arbitration();
      test_corners();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
